// File: rtl/axis_serial_tx.sv
// axis_serial_tx: serialises an AXI-Stream byte stream into preamble/start/data/last/stop framed bits on one line
module axis_serial_tx #(
    parameter int DATA_W       = 8,
    parameter int PREAMBLE_LEN = 8,
    parameter int IDLE_MIN     = 4
) (
    input  logic              ref_clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    output logic              tx_out,
    output logic              busy
);
    localparam int MAXC = (PREAMBLE_LEN > DATA_W) ?
                          ((PREAMBLE_LEN > IDLE_MIN) ? PREAMBLE_LEN : IDLE_MIN) :
                          ((DATA_W > IDLE_MIN) ? DATA_W : IDLE_MIN);
    localparam int CW = $clog2(MAXC + 1);
    // Preamble bit k is ~k[0]; with a down-counter k = PREAMBLE_LEN-1-cnt, so k[0] = PAR0 ^ cnt[0]
    localparam logic PAR0 = 1'((PREAMBLE_LEN - 1) % 2);

    typedef enum logic [2:0] {IDLE, PREAMBLE, START, DATA, LAST, STOP, HOLD, GAP} state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [DATA_W-1:0] sh, sh_n;
    logic              last_q, last_n, tx_n, xfer;

    assign s_axis_tready = !rst && (state == IDLE || state == HOLD || (state == STOP && !last_q));
    assign xfer          = s_axis_tvalid && s_axis_tready;
    assign busy          = state != IDLE;

    // Next-state, counter and shift-register update; the line level is derived from the next state so tx_out is registered
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sh_n    = sh;
        last_n  = last_q;
        if (xfer) begin
            sh_n   = s_axis_tdata;
            last_n = s_axis_tlast;
        end
        case (state)
            IDLE: if (xfer) begin
                state_n = PREAMBLE;
                cnt_n   = CW'(PREAMBLE_LEN - 1);
            end
            PREAMBLE: if (cnt == 0) state_n = START;
                      else cnt_n = cnt - 1'b1;
            START: begin
                state_n = DATA;
                cnt_n   = CW'(DATA_W - 1);
            end
            DATA: begin
                sh_n = sh >> 1;
                if (cnt == 0) state_n = LAST;
                else cnt_n = cnt - 1'b1;
            end
            LAST: state_n = STOP;
            STOP: if (last_q) begin
                state_n = GAP;
                cnt_n   = CW'(IDLE_MIN - 1);
            end else state_n = xfer ? START : HOLD;
            HOLD: if (xfer) state_n = START;
            GAP: if (cnt == 0) state_n = IDLE;
                 else cnt_n = cnt - 1'b1;
            default: state_n = IDLE;
        endcase
        tx_n = (state_n == PREAMBLE) ? ~(PAR0 ^ cnt_n[0]) :
               (state_n == START)    ? 1'b0 :
               (state_n == DATA)     ? sh_n[0] :
               (state_n == LAST)     ? last_n : 1'b1;
    end

    // State register with synchronous reset that aborts any frame and returns the line high
    always_ff @(posedge ref_clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            sh     <= '0;
            last_q <= 1'b0;
            tx_out <= 1'b1;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            sh     <= sh_n;
            last_q <= last_n;
            tx_out <= tx_n;
        end
    end
endmodule
